// File: rtl/grasspopper_encoder.sv
// grasspopper_encoder: 256-bit parallel-to-serial frame encoder, MSB first.
// Define GP_SCRAMBLE_EN to whiten the stream with an additive x^7+x^6+1 LFSR.
module grasspopper_encoder (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] data_i,
  output logic         data_o,
  output logic         busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [8:0] LAST = 9'd256;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [255:0] r_shreg;
  logic [255:0] w_shreg_nxt;
  logic [8:0]   r_cnt;
  logic [8:0]   w_cnt_nxt;
  logic         r_busy;
  logic         w_busy_nxt;
  logic         r_data;
  logic         w_data_nxt;
  logic         w_s;
  logic         w_last;

`ifdef GP_SCRAMBLE_EN
  localparam logic [6:0] SEED = 7'h7F;

  logic [6:0] r_lfsr;
  logic [6:0] w_lfsr_nxt;

  assign w_s = r_lfsr[6] ^ r_lfsr[5];
`else
  assign w_s = 1'b0;
`endif

  assign w_last = (r_cnt == LAST);
  assign data_o = r_data;
  assign busy   = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_data  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_data  <= w_data_nxt;
    end
  end

`ifdef GP_SCRAMBLE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_data_nxt  = r_data;
`ifdef GP_SCRAMBLE_EN
    w_lfsr_nxt  = r_lfsr;
`endif
    unique case (r_state)
      IDLE: begin
        // capture edge; the lead-in cycle carries no payload
        w_shreg_nxt = data_i;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b1;
        w_data_nxt  = 1'b0;
        w_state_nxt = SHIFT;
`ifdef GP_SCRAMBLE_EN
        w_lfsr_nxt  = SEED;
`endif
      end
      SHIFT: begin
        if (w_last) begin
          w_busy_nxt  = 1'b0;
          w_data_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_data_nxt  = r_shreg[255] ^ w_s;
          w_shreg_nxt = {r_shreg[254:0], 1'b0};
          w_cnt_nxt   = r_cnt + 9'd1;
`ifdef GP_SCRAMBLE_EN
          w_lfsr_nxt  = {r_lfsr[5:0], w_s};
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_grasspopper_encoder.sv
// Testbench for grasspopper_encoder: payload table, back-to-back frames,
// resample gap and mid-frame reset against a queue-based scrambler model.
module tb_grasspopper_encoder;

  logic         clk;
  logic         reset;
  logic [255:0] data_i;
  logic         data_o;
  logic         busy;

  int n_pass;
  int n_total;

  grasspopper_encoder dut (
    .clk    (clk),
    .reset  (reset),
    .data_i (data_i),
    .data_o (data_o),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] din;
    logic [255:0] exp;
  } vec_t;

  vec_t         tbl[6];
  logic [255:0] mask;
  logic [255:0] got;

  // Scrambler bit k is s_k; the LFSR is a sliding window of 7 bits,
  // oldest first, where s = oldest ^ next-oldest.
  function automatic logic [255:0] scr_mask();
    logic [255:0] m;
    logic         q[$];
    logic         s;
    m = '0;
`ifdef GP_SCRAMBLE_EN
    for (int i = 0; i < 7; i++) q.push_back(1'b1);
    for (int k = 0; k < 256; k++) begin
      s = q[0] ^ q[1];
      m[255-k] = s;
      void'(q.pop_front());
      q.push_back(s);
    end
`else
    q.push_back(1'b0);
    s = q[0];
    m[0] = s;
`endif
    return m;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input logic [255:0] d);
    @(negedge clk);
    reset  = 1'b1;
    data_i = d;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Next posedge is the capture edge; ends just after the gap edge.
  task automatic do_frame(input string tag, input logic [255:0] exp,
                          output logic [255:0] bits);
    int bb;
    bb = 0;
    bits = '0;
    @(posedge clk);
    #1;
    chk({tag, "_lead"}, 256'({busy, data_o}), 256'(2'b10));
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      #1;
      bits[256-k] = data_o;
      if (busy !== 1'b1) bb++;
    end
    chk({tag, "_bits"}, bits, exp);
    chk({tag, "_busy"}, 256'(bb), 256'd0);
    @(posedge clk);
    #1;
    chk({tag, "_gap"}, 256'({busy, data_o}), 256'(2'b00));
  endtask

  initial begin
    logic [255:0] d1;
    logic [255:0] d2;
    logic [6:0]   head;
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    data_i  = '0;
    mask    = scr_mask();

    #3;
    chk("rst_async", 256'({busy, data_o}), 256'(2'b00));
    @(posedge clk);
    #1;
    chk("rst_hold1", 256'({busy, data_o}), 256'(2'b00));
    @(posedge clk);
    #1;
    chk("rst_hold2", 256'({busy, data_o}), 256'(2'b00));

    tbl[0] = '{"a5", {32{8'hA5}}, '0};
    tbl[1] = '{"zero", '0, '0};
    tbl[2] = '{"ones", '1, '0};
    tbl[3] = '{"rnd0", rnd256(), '0};
    tbl[4] = '{"rnd1", rnd256(), '0};
    tbl[5] = '{"rnd2", rnd256(), '0};
    for (int i = 0; i < 6; i++) tbl[i].exp = tbl[i].din ^ mask;

    for (int i = 0; i < 6; i++) begin
      apply_reset(tbl[i].din);
      do_frame({tbl[i].name, "_f1"}, tbl[i].exp, got);
      if (i == 1) begin
        head = got[255:249];
`ifdef GP_SCRAMBLE_EN
        chk("scr_head", 256'(head), 256'(7'b0000001));
`else
        chk("raw_head", 256'(head), 256'(7'b0000000));
`endif
      end
      if (i == 0) begin
        chk("a5_head", 256'(got[255:248] ^ mask[255:248]),
            256'(8'b10100101));
      end
      do_frame({tbl[i].name, "_f2"}, tbl[i].exp, got);
    end

    apply_reset('0);
    fork
      do_frame("rs_f1", mask, got);
      begin
        repeat (101) @(posedge clk);
        #2;
        data_i = '1;
      end
    join
    do_frame("rs_f2", ~mask, got);

    d1 = rnd256();
    d2 = rnd256();
    apply_reset(d1);
    repeat (51) @(posedge clk);
    #1;
    chk("mid_busy", 256'(busy), 256'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_async", 256'({busy, data_o}), 256'(2'b00));
    data_i = d2;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_hold", 256'({busy, data_o}), 256'(2'b00));
    @(negedge clk);
    reset = 1'b0;
    do_frame("mid_re", d2 ^ mask, got);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/grasspopper_encoder.md
# grasspopper_encoder

Serial frame encoder: captures a 256-bit parallel word, then streams it out one bit per clock, MSB first, optionally whitened by an additive 7-bit LFSR scrambler. It sits between a wide parallel data source and a 1-bit serial link. It is free-running: frames repeat back-to-back with a one-cycle idle gap. Implemented as module `grasspopper_encoder`.

## Interface

- No parameters. Frame width is fixed at 256 bits; LFSR width is fixed at 7 bits.
- `clk  input  1` — single clock; all state updates on the rising edge.
- `reset  input  1` — reset is asynchronous and active-high.
- `data_i  input  256` — parallel payload, sampled only on the capture edge.
- `data_o  output  1` — serial encoded bit, registered.
- `busy  output  1` — registered; high while a frame is in progress (capture cycle plus 256 bit cycles).

## Operation

- Internal state:
  - 256-bit shift register `shreg`.
  - 9-bit bit counter `cnt`.
  - 7-bit LFSR `lfsr`.
  - FSM with states IDLE and SHIFT.
- Reset (asynchronous) drives: state=IDLE, `busy`=0, `data_o`=0, `shreg`=0, `cnt`=0, `lfsr`=7'h7F.
- IDLE, on each rising edge:
  - `shreg`<=`data_i`, `cnt`<=0, `lfsr`<=7'h7F.
  - `busy`<=1, `data_o`<=0, state<=SHIFT.
- SHIFT, when `cnt`<256, on each rising edge:
  - Compute s = `lfsr[6]` XOR `lfsr[5]` (scrambler enabled) or s = 0 (disabled).
  - `data_o` <= `shreg[255]` XOR s.
  - `shreg` <= `shreg`<<1 (zero fill).
  - `lfsr` <= {`lfsr[5:0]`, s}.
  - `cnt` <= `cnt`+1.
- SHIFT, when `cnt`==256: `busy`<=0, `data_o`<=0, state<=IDLE.
- Bit order: `data_i[255]` is sent first and `data_i[0]` last.
- Changes on `data_i` during SHIFT are ignored.
- No back-pressure and no start input. The block transmits continuously from reset release.

## Timing

- Let E0 be the first rising edge after `reset` deasserts (the capture edge).
- After E0: `busy`=1, `data_o`=0 (lead-in cycle; no payload bit yet).
- After edge Ek, k=1..256: `data_o` carries encoded bit k-1, i.e. `data_i[256-k]` from the capture. Each bit is held for exactly one cycle.
- After E257: `busy`=0, `data_o`=0 for exactly one cycle.
- E258 is the next capture edge. Frame period is 258 cycles, with `busy` high for 257 of them.
- Reset asserted mid-frame: outputs clear immediately, without waiting for a clock. The frame is abandoned. After release, the sequence restarts at E0 with a fresh capture and seed.
- Reset held across edges: no state change; `busy`=0, `data_o`=0.
- The LFSR is reseeded to 7'h7F at every capture, so every frame is scrambled identically and independently of previous frames.

## Configuration

- Macro `GP_SCRAMBLE_EN`:
  - Defined: s = `lfsr[6]` XOR `lfsr[5]` (polynomial x^7+x^6+1). Output is the payload XOR the scrambler sequence.
  - Undefined: s is forced to 0 and the LFSR logic may be omitted. `data_o` is the raw payload bit.
- Timing, `busy` behaviour and frame length are identical in both builds.

## Test plan

- Reset check: `reset`=1, then sample asynchronously mid-cycle → `busy`=0 and `data_o`=0 immediately; they stay 0 while `reset` is held for 2 cycles.
- Raw stream (`GP_SCRAMBLE_EN` undefined):
  - Stimulus: `data_i`=256'hA5 repeated as 32 bytes, release reset.
  - Required: `busy` rises after E0; bits after E1..E8 are 1,0,1,0,0,1,0,1 and the pattern repeats through E256; `busy`=0 after E257.
- Scrambler sequence (`GP_SCRAMBLE_EN` defined):
  - Stimulus: `data_i`=0.
  - Required: bits after E1..E7 are 0,0,0,0,0,0,1. The full 256-bit frame equals the x^7+x^6+1 sequence from seed 7'h7F, and the next frame is identical.
- Scrambler involution (`GP_SCRAMBLE_EN` defined):
  - Stimulus: `data_i`=all ones.
  - Required: each output bit equals the inverse of the corresponding bit in the `data_i`=0 run.
- Frame gap and resample:
  - Stimulus: change `data_i` from 0 to all-ones at E100 (unscrambled build).
  - Required: bits of the current frame stay 0. `busy` is low for exactly one cycle after E257. The second frame outputs all ones, starting after E259.
- Reset mid-frame: assert `reset` after E50, release 3 cycles later → outputs clear immediately; a new E0 capture follows and the frame restarts from `data_i[255]` with seed 7'h7F.
